ysyx_24100012_partial_load: RTL

- Load-side counterpart of the partial-store path: accepts one load request (address + funct3) from the LSU stage and issues a word-aligned read on a valid/ready memory read port.
- Extracts the addressed byte, halfword or word from the returned word, sign- or zero-extends it, and hands the result back over a valid/ready response.
- Sits between the execute/LSU stage and the data-memory read channel; one outstanding load at a time.

---
 rtl/ysyx_24100012_partial_load_pkg.sv | 16 +
 rtl/ysyx_24100012_partial_load_if.sv | 17 +
 rtl/ysyx_24100012_MuxKeyWithDefault.sv | 19 +
 rtl/ysyx_24100012_partial_load_extract.sv | 29 ++
 rtl/ysyx_24100012_partial_load.sv | 69 ++++++
 5 files changed

// File: rtl/ysyx_24100012_partial_load_pkg.sv
// ysyx_24100012_partial_load_pkg: shared load funct3 encodings, FSM states and response codes
package ysyx_24100012_partial_load_pkg;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RESP} state_e;
   // Illegal funct3 or a halfword/word access off its natural alignment
   function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] off);
      return (f3 == F3_LH || f3 == F3_LHU) ? off[0] :
             (f3 == F3_LW)                 ? |off   :
                                             !(f3 == F3_LB || f3 == F3_LBU);
   endfunction
endpackage

// File: rtl/ysyx_24100012_partial_load_if.sv
// ysyx_24100012_partial_load_if: data-memory read channel (address + data phases)
//   master: arvalid/araddr/rready out, arready/rvalid/rdata/rresp in (the load unit)
//   slave : the memory side
interface ysyx_24100012_partial_load_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  rvalid;
   logic                  rready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   modport master(output arvalid, araddr, rready, input arready, rvalid, rdata, rresp);
   modport slave(input arvalid, araddr, rready, output arready, rvalid, rdata, rresp);
endinterface

// File: rtl/ysyx_24100012_MuxKeyWithDefault.sv
// ysyx_24100012_MuxKeyWithDefault: key-indexed lookup mux with default
//   key: selector, lut: NR_KEY packed {key,data} pairs, default_out: no-match value, out: selected data
module ysyx_24100012_MuxKeyWithDefault #(
   parameter int NR_KEY   = 2,
   parameter int KEY_LEN  = 1,
   parameter int DATA_LEN = 1
) (
   output logic [DATA_LEN-1:0]                out,
   input  logic [KEY_LEN-1:0]                 key,
   input  logic [DATA_LEN-1:0]                default_out,
   input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);
   localparam int PAIR_LEN = KEY_LEN + DATA_LEN;
   always_comb begin
      out = default_out;
      for (int i = 0; i < NR_KEY; i++)
         if (lut[PAIR_LEN*i+DATA_LEN +: KEY_LEN] == key) out = lut[PAIR_LEN*i +: DATA_LEN];
   end
endmodule

// File: rtl/ysyx_24100012_partial_load_extract.sv
// ysyx_24100012_load_extract: combinational byte/halfword/word lane select with sign/zero extension
//   word: aligned memory word, off: addr[1:0], func3: load type, data: extended result
module ysyx_24100012_load_extract
   import ysyx_24100012_partial_load_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [2:0]  func3,
   output logic [31:0] data
);
   logic [7:0]  b;
   logic [15:0] h;
   ysyx_24100012_MuxKeyWithDefault #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) u_byte (
      .out(b), .key(off), .default_out(8'h00),
      .lut({2'd3, word[31:24], 2'd2, word[23:16], 2'd1, word[15:8], 2'd0, word[7:0]})
   );
   ysyx_24100012_MuxKeyWithDefault #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(16)) u_half (
      .out(h), .key(off[1]), .default_out(16'h0000),
      .lut({1'b1, word[31:16], 1'b0, word[15:0]})
   );
   ysyx_24100012_MuxKeyWithDefault #(.NR_KEY(5), .KEY_LEN(3), .DATA_LEN(32)) u_ext (
      .out(data), .key(func3), .default_out(32'h0),
      .lut({F3_LB,  {{24{b[7]}}, b},
            F3_LH,  {{16{h[15]}}, h},
            F3_LW,  word,
            F3_LBU, {24'h0, b},
            F3_LHU, {16'h0, h}})
   );
endmodule

// File: rtl/ysyx_24100012_partial_load.sv
// ysyx_24100012_partial_load: single-outstanding RV32 load unit over a valid/ready read channel
//   req_*  : load request (addr, func3) from the LSU stage
//   mem    : word-aligned read channel (master side)
//   load_* : extended result + error back to the pipeline
module ysyx_24100012_partial_load
   import ysyx_24100012_partial_load_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            func3,
   input  logic [ADDR_WIDTH-1:0] addr,
   ysyx_24100012_partial_load_if.master mem,
   output logic                  load_valid,
   input  logic                  load_ready,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_err
);
   state_e                state, state_n;
   logic [1:0]            off_q;
   logic [2:0]            f3_q;
   logic [ADDR_WIDTH-1:0] araddr_q;
   logic [DATA_WIDTH-1:0] ext;
   logic                  bad;
   assign bad = load_bad(func3, addr[1:0]);
   ysyx_24100012_load_extract u_extract (.word(mem.rdata), .off(off_q), .func3(f3_q), .data(ext));
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= S_IDLE;
      else state <= state_n;
   // Bad requests skip the memory entirely and answer with an error
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  state_n = !req_valid ? S_IDLE : bad ? S_RESP : S_AR;
         S_AR:    state_n = mem.arready ? S_R : S_AR;
         S_R:     state_n = mem.rvalid ? S_RESP : S_R;
         S_RESP:  state_n = load_ready ? S_IDLE : S_RESP;
         default: state_n = S_IDLE;
      endcase
   end
   always_comb begin
      req_ready   = state == S_IDLE;
      mem.arvalid = state == S_AR;
      mem.rready  = state == S_R;
      load_valid  = state == S_RESP;
   end
   assign mem.araddr = araddr_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         off_q     <= '0;
         f3_q      <= '0;
         araddr_q  <= '0;
         load_data <= '0;
         load_err  <= 1'b0;
      end else if (state == S_IDLE && req_valid) begin
         off_q     <= addr[1:0];
         f3_q      <= func3;
         araddr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
         load_data <= '0;
         load_err  <= bad;
      end else if (state == S_R && mem.rvalid) begin
         load_data <= ext;
         load_err  <= mem.rresp != RESP_OKAY;
      end
endmodule
